// File: rtl/sine_pwm_pkg.sv
// Shared widths, midscale constant and the sample-to-duty scaling helper for the sine PWM DAC.
package sine_pwm_pkg;

    localparam int DEF_SAMPLE_W = 8;
    localparam int DEF_PWM_W    = 8;
    localparam int DEF_AMP_W    = 4;

    localparam logic [DEF_SAMPLE_W-1:0] MIDSCALE = {1'b1, {(DEF_SAMPLE_W-1){1'b0}}};

    // Signed sample times unsigned gain, floor-divided by 2**amp_w, shifted to offset binary.
    // Callers keep the low SAMPLE_W bits; the result always fits, so no saturation.
    function automatic logic [31:0] scale_to_duty(
        input logic signed [31:0] sample,
        input logic        [31:0] gain,
        input int                 amp_w,
        input logic        [31:0] midscale
    );
        logic signed [31:0] prod;
        logic signed [31:0] shifted;
        prod    = sample * $signed(gain);
        shifted = prod >>> amp_w;
        return shifted + midscale;
    endfunction

endpackage

// File: rtl/sine_pwm_dac_if.sv
// Sample stream into the PWM DAC: signed sample with valid/ready handshake.
interface sine_pwm_dac_if import sine_pwm_pkg::*; #(
    parameter int SAMPLE_W = DEF_SAMPLE_W
);
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic                       sample_ready;

    modport master (output sample_in, output sample_valid, input  sample_ready);
    modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_compare_counter.sv
// Free-running PWM period counter with registered duty compare and period markers.
module pwm_compare_counter #(
    parameter int PWM_W    = 8,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] duty,
    output logic                boundary,
    output logic                pwm_out,
    output logic                period_start
);
    localparam int CMP_W = (PWM_W > SAMPLE_W) ? PWM_W : SAMPLE_W;

    logic [PWM_W-1:0] cnt_reg;
    logic             pwm_out_reg;
    logic             period_start_reg;

    // Last cycle of the period: the only cycle where duty may be reloaded.
    assign boundary     = &cnt_reg;
    assign pwm_out      = pwm_out_reg;
    assign period_start = period_start_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg          <= '0;
            pwm_out_reg      <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            cnt_reg          <= cnt_reg + PWM_W'(1);
            pwm_out_reg      <= CMP_W'(cnt_reg) < CMP_W'(duty);
            period_start_reg <= boundary;
        end
    end

endmodule

// File: rtl/sine_pwm_dac.sv
// Sine sample PWM output stage: handshake, one-deep hold, gain scaling, mute.
// Optional PWM_SOFT_MUTE_EN: gain ramps one step per period toward amplitude (or 0 while muted).
module sine_pwm_dac import sine_pwm_pkg::*; #(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int PWM_W    = DEF_PWM_W,
    parameter int AMP_W    = DEF_AMP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    sine_pwm_dac_if.slave        sif,
    input  logic [AMP_W-1:0]     amplitude,
    input  logic                 mute,
    output logic                 pwm_out,
    output logic                 period_start,
    output logic                 underrun
);
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic                boundary;
    logic                accept;
    logic [AMP_W-1:0]    gain;
    logic [SAMPLE_W-1:0] scaled_duty;
    logic [SAMPLE_W-1:0] duty_load;
    logic                load_en;

    logic                hold_full_reg;
    logic [SAMPLE_W-1:0] hold_duty_reg;
    logic [SAMPLE_W-1:0] duty_active_reg;
    logic                underrun_reg;

    // The boundary cycle drains the hold, so a new sample may enter in that same cycle.
    assign sif.sample_ready = !hold_full_reg || boundary;
    assign accept           = sif.sample_valid && sif.sample_ready;
    assign underrun         = underrun_reg;

    assign scaled_duty = SAMPLE_W'(scale_to_duty(32'(sif.sample_in), 32'(gain), AMP_W, 32'(MID)));

`ifdef PWM_SOFT_MUTE_EN
    logic [AMP_W-1:0] gain_reg;
    logic [AMP_W-1:0] gain_target;

    assign gain_target = mute ? '0 : amplitude;
    assign gain        = gain_reg;
    assign duty_load   = hold_duty_reg;
    assign load_en     = hold_full_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_reg <= '0;
        end else if (boundary) begin
            if (gain_reg < gain_target) begin
                gain_reg <= gain_reg + AMP_W'(1);
            end else if (gain_reg > gain_target) begin
                gain_reg <= gain_reg - AMP_W'(1);
            end
        end
    end
`else
    // Hard mute overrides whatever the hold contains, even when it is empty.
    assign gain      = amplitude;
    assign duty_load = mute ? MID : hold_duty_reg;
    assign load_en   = hold_full_reg || mute;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_reg   <= 1'b0;
            hold_duty_reg   <= MID;
            duty_active_reg <= MID;
            underrun_reg    <= 1'b0;
        end else begin
            if (accept) begin
                hold_full_reg <= 1'b1;
                hold_duty_reg <= scaled_duty;
            end else if (boundary) begin
                hold_full_reg <= 1'b0;
            end
            if (boundary && load_en) begin
                duty_active_reg <= duty_load;
            end
            underrun_reg <= boundary && !hold_full_reg;
        end
    end

    pwm_compare_counter #(
        .PWM_W    (PWM_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_pwm (
        .clk          (clk),
        .rst          (rst),
        .duty         (duty_active_reg),
        .boundary     (boundary),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

endmodule

// File: tb/tb_sine_pwm_dac.sv
// Directed bench for sine_pwm_dac: one line per period window or check, hand-computed duties.
module tb_sine_pwm_dac;

    logic       clk;
    logic       rst;
    logic [3:0] amplitude;
    logic       mute;
    logic       pwm_out;
    logic       period_start;
    logic       underrun;

    int tests_run;
    int tests_failed;

    sine_pwm_dac_if #(.SAMPLE_W(8)) sif ();

    sine_pwm_dac dut (
        .clk          (clk),
        .rst          (rst),
        .sif          (sif),
        .amplitude    (amplitude),
        .mute         (mute),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next negedge where period_start is high (cnt==0); counts underrun pulses on the way.
    task automatic align(output int upulses, output bit ok);
        upulses = 0;
        ok      = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (underrun) upulses++;
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Observe one full period window (cnt 1..255 then cnt 0 of the next period).
    // With ramp set, each accepted sample is replaced by sample+32 right after the accepting edge.
    task automatic measure(input bit ramp, output int highs, output int upulses,
                           output int accepts, output int acc_idx, output int pstarts);
        highs = 0; upulses = 0; accepts = 0; acc_idx = -1; pstarts = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) highs++;
            if (underrun) upulses++;
            if (period_start) pstarts++;
            if (sif.sample_valid && sif.sample_ready) begin
                accepts++;
                acc_idx = i;
                if (ramp) begin
                    @(posedge clk);
                    #1 sif.sample_in = sif.sample_in + 8'sd32;
                end
            end
        end
        $display("[TB] window: high=%0d underrun=%0d accepts=%0d acc_idx=%0d pstart=%0d",
                 highs, upulses, accepts, acc_idx, pstarts);
    endtask

    task automatic send(input logic signed [7:0] s, input logic [3:0] amp, output bit ok);
        ok = 1'b0;
        sif.sample_in    = s;
        amplitude        = amp;
        sif.sample_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (sif.sample_ready) begin
                @(posedge clk);
                #1 sif.sample_valid = 1'b0;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        sif.sample_valid = 1'b0;
        $display("[TB] send sample=%0d amp=%0d accepted=%0d", s, amp, ok);
    endtask

    task automatic test_reset();
        int h, u, a, ai, ps;
        bit ok;
        @(negedge clk);
        tests_run++;
        if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL rst_pwm_out: got %b expected 0", pwm_out); end
        tests_run++;
        if (period_start !== 1'b0) begin tests_failed++; $display("FAIL rst_period_start: got %b expected 0", period_start); end
        tests_run++;
        if (underrun !== 1'b0) begin tests_failed++; $display("FAIL rst_underrun: got %b expected 0", underrun); end
        tests_run++;
        if (sif.sample_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b expected 1", sif.sample_ready); end
        rst = 1'b0;
        align(u, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rst_align: no period_start within bound"); end
        tests_run++;
        if (u !== 1) begin tests_failed++; $display("FAIL rst_first_underrun: got %0d expected 1", u); end
        for (int p = 0; p < 3; p++) begin
            measure(1'b0, h, u, a, ai, ps);
            tests_run++;
            if (h !== 128) begin tests_failed++; $display("FAIL idle_duty p%0d: got %0d expected 128", p, h); end
            tests_run++;
            if (u !== 1) begin tests_failed++; $display("FAIL idle_underrun p%0d: got %0d expected 1", p, u); end
            tests_run++;
            if (ps !== 1) begin tests_failed++; $display("FAIL idle_pstart p%0d: got %0d expected 1", p, ps); end
        end
    endtask

    task automatic test_scaling();
        int h, u, a, ai, ps;
        bit ok;
        send(8'sd127, 4'd15, ok);
        amplitude = 4'd0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL pos_send: not accepted"); end
        align(u, ok);
        tests_run++;
        if (!ok || u !== 0) begin tests_failed++; $display("FAIL pos_align: ok=%0d underrun=%0d expected ok=1 underrun=0", ok, u); end
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 247) begin tests_failed++; $display("FAIL pos_duty: got %0d expected 247", h); end
        tests_run++;
        if (u !== 1) begin tests_failed++; $display("FAIL pos_underrun: got %0d expected 1", u); end
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 247) begin tests_failed++; $display("FAIL pos_duty_kept: got %0d expected 247", h); end
        send(-8'sd127, 4'd15, ok);
        amplitude = 4'd3;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL neg_send: not accepted"); end
        align(u, ok);
        tests_run++;
        if (!ok || u !== 0) begin tests_failed++; $display("FAIL neg_align: ok=%0d underrun=%0d expected ok=1 underrun=0", ok, u); end
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 8) begin tests_failed++; $display("FAIL neg_duty: got %0d expected 8", h); end
    endtask

    task automatic test_tied_valid();
        int h, u, a, ai, ps;
        int exp_duty [3] = '{68, 98, 128};
        amplitude        = 4'd15;
        sif.sample_in    = -8'sd64;
        sif.sample_valid = 1'b1;
        @(posedge clk);
        #1 sif.sample_in = -8'sd32;
        measure(1'b1, h, u, a, ai, ps);
        tests_run++;
        if (h !== 8) begin tests_failed++; $display("FAIL tied_warm_duty: got %0d expected 8", h); end
        tests_run++;
        if (a !== 1 || ai !== 254 || u !== 0) begin
            tests_failed++;
            $display("FAIL tied_warm_accept: accepts=%0d idx=%0d underrun=%0d expected 1/254/0", a, ai, u);
        end
        for (int p = 0; p < 3; p++) begin
            measure(1'b1, h, u, a, ai, ps);
            tests_run++;
            if (h !== exp_duty[p]) begin tests_failed++; $display("FAIL tied_duty p%0d: got %0d expected %0d", p, h, exp_duty[p]); end
            tests_run++;
            if (a !== 1 || ai !== 254) begin
                tests_failed++;
                $display("FAIL tied_accept p%0d: accepts=%0d idx=%0d expected 1 at 254", p, a, ai);
            end
            tests_run++;
            if (u !== 0) begin tests_failed++; $display("FAIL tied_underrun p%0d: got %0d expected 0", p, u); end
        end
        sif.sample_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int h, u, a, ai, ps;
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 158 || u !== 0) begin
            tests_failed++;
            $display("FAIL b2b_drain1: duty=%0d underrun=%0d expected 158/0", h, u);
        end
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 188 || u !== 1) begin
            tests_failed++;
            $display("FAIL b2b_drain2: duty=%0d underrun=%0d expected 188/1", h, u);
        end
    endtask

    task automatic test_mute();
        int h, u, a, ai, ps;
        amplitude        = 4'd15;
        sif.sample_in    = 8'sd96;
        sif.sample_valid = 1'b1;
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 188 || a !== 1 || u !== 0) begin
            tests_failed++;
            $display("FAIL mute_pre: duty=%0d accepts=%0d underrun=%0d expected 188/1/0", h, a, u);
        end
        mute = 1'b1;
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 218) begin tests_failed++; $display("FAIL mute_no_midperiod: got %0d expected 218", h); end
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 128 || a !== 1 || u !== 0) begin
            tests_failed++;
            $display("FAIL mute_mid: duty=%0d accepts=%0d underrun=%0d expected 128/1/0", h, a, u);
        end
        mute = 1'b0;
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 128) begin tests_failed++; $display("FAIL unmute_lag: got %0d expected 128", h); end
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 218) begin tests_failed++; $display("FAIL unmute_duty: got %0d expected 218", h); end
    endtask

    task automatic test_reset_mid();
        int h, u, a, ai, ps;
        bit ok;
        sif.sample_in = 8'sd127;
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 218) begin tests_failed++; $display("FAIL rmid_pre_duty: got %0d expected 218", h); end
        sif.sample_valid = 1'b0;
        repeat (40) @(negedge clk);
        tests_run++;
        if (pwm_out !== 1'b1) begin tests_failed++; $display("FAIL rmid_pwm_before: got %b expected 1", pwm_out); end
        rst = 1'b1;
        #1;
        tests_run++;
        if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL rmid_pwm_async: got %b expected 0", pwm_out); end
        tests_run++;
        if (sif.sample_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_ready: got %b expected 1", sif.sample_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        align(u, ok);
        tests_run++;
        if (!ok || u !== 1) begin
            tests_failed++;
            $display("FAIL rmid_discard: ok=%0d underrun=%0d expected ok=1 underrun=1", ok, u);
        end
        measure(1'b0, h, u, a, ai, ps);
        tests_run++;
        if (h !== 128 || u !== 1) begin
            tests_failed++;
            $display("FAIL rmid_post: duty=%0d underrun=%0d expected 128/1", h, u);
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        rst              = 1'b1;
        amplitude        = 4'd0;
        mute             = 1'b0;
        sif.sample_in    = '0;
        sif.sample_valid = 1'b0;
        test_reset();
        test_scaling();
        test_tied_valid();
        test_back_to_back();
        test_mute();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
